// File: rtl/fx2_slave_fifo_writer.sv
// fx2_slave_fifo_writer
// Write-side master for the CY7C68013A (FX2) Slave FIFO interface. A 16-bit
// valid/ready stream is captured into a small skid buffer and drained into the
// selected endpoint FIFO at up to one word per USB_IFCLK while FLAGB# reports
// space. All FX2-facing outputs are registered.
//
// Build option: define FX2_SHORT_PKT_EN to commit partial packets with PKTEND#
// after TIMEOUT idle cycles. Without it only full packets reach the host.
//
// state   | meaning
// S_IDLE  | transfer disabled, FD released (FD_OE=0), no strobes
// S_WRITE | FD driven, one SLWR# per cycle while FLAGB# high and data buffered
// S_FLUSH | SLWR# gap cycle, PKTEND# strobes next cycle (short-packet build only)
module fx2_slave_fifo_writer #(
  parameter int         DATA_W    = 16,
  parameter int         BUF_AW    = 4,
  parameter int         PKT_WORDS = 256,
  parameter logic [1:0] EP_ADDR   = 2'b10
`ifdef FX2_SHORT_PKT_EN
  ,
  parameter int         TIMEOUT   = 1024
`endif
) (
  input  logic              USB_IFCLK,
  input  logic              USB_RESET,
  input  logic              ENABLE,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic              USB_FLAGB_N,
  output logic [DATA_W-1:0] USB_FD,
  output logic              USB_FD_OE,
  output logic              USB_SLWR_N,
  output logic              USB_SLRD_N,
  output logic              USB_SLOE_N,
  output logic [1:0]        USB_FIFOADR,
  output logic              USB_PKTEND_N,
  output logic [31:0]       WORDS_SENT
);

  localparam int DEPTH = 2**BUF_AW;
  localparam int PKT_W = $clog2(PKT_WORDS);
  localparam logic [PKT_W-1:0] PKT_LAST = PKT_W'(PKT_WORDS - 1);
`ifdef FX2_SHORT_PKT_EN
  localparam int TMR_W = $clog2(TIMEOUT);
  // Reload two short of TIMEOUT: one cycle is spent in FLUSH and PKTEND# is
  // registered, so the strobe lands TIMEOUT+1 cycles after the last SLWR#.
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 2);
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [BUF_AW-1:0]   wr_ptr;
  logic [BUF_AW-1:0]   rd_ptr;
  logic [BUF_AW:0]     count;
  logic [PKT_W-1:0]    pkt_cnt;
  logic                push;
  logic                pop;
`ifdef FX2_SHORT_PKT_EN
  logic [TMR_W-1:0]    idle_tmr;
`endif

  // Handshake and write decision; the decision pops the head in the same
  // cycle so the word appears on FD together with SLWR# one cycle later.
  always_comb begin
    IN_READY = ~USB_RESET & (count != (BUF_AW+1)'(DEPTH));
    push     = IN_VALID & IN_READY;
    pop      = (state == S_WRITE) & ENABLE & USB_FLAGB_N & (count != '0);
  end

  // Buffer storage; contents need no reset, emptiness is tracked by count.
  always_ff @(posedge USB_IFCLK) begin
    if (push) mem[wr_ptr] <= IN_DATA;
  end

  // Buffer pointers and occupancy.
  always_ff @(posedge USB_IFCLK or posedge USB_RESET) begin
    if (USB_RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Transfer FSM with registered FX2 strobes, data and packet bookkeeping.
  always_ff @(posedge USB_IFCLK or posedge USB_RESET) begin
    if (USB_RESET) begin
      state        <= S_IDLE;
      USB_SLWR_N   <= 1'b1;
      USB_PKTEND_N <= 1'b1;
      USB_FD       <= '0;
      USB_FD_OE    <= 1'b0;
      pkt_cnt      <= '0;
`ifdef FX2_SHORT_PKT_EN
      idle_tmr     <= TMR_LOAD;
`endif
    end else begin
      USB_SLWR_N   <= 1'b1;
      USB_PKTEND_N <= 1'b1;
      if (pop) begin
        USB_SLWR_N <= 1'b0;
        USB_FD     <= mem[rd_ptr];
        pkt_cnt    <= (pkt_cnt == PKT_LAST) ? '0 : pkt_cnt + 1'b1;
      end
`ifdef FX2_SHORT_PKT_EN
      if ((state != S_WRITE) || !USB_SLWR_N)
        idle_tmr <= TMR_LOAD;
      else if ((pkt_cnt != '0) && (idle_tmr != '0))
        idle_tmr <= idle_tmr - 1'b1;
`endif
      case (state)
        S_IDLE: begin
          if (ENABLE) begin
            state     <= S_WRITE;
            USB_FD_OE <= 1'b1;
          end
        end
        S_WRITE: begin
          if (!ENABLE) begin
            state     <= S_IDLE;
            USB_FD_OE <= 1'b0;
          end
`ifdef FX2_SHORT_PKT_EN
          // Only leave when SLWR# is already high so FLUSH is a clean gap.
          else if (!pop && USB_SLWR_N && (pkt_cnt != '0) && (idle_tmr == '0)) begin
            state <= S_FLUSH;
          end
`endif
        end
        S_FLUSH: begin
`ifdef FX2_SHORT_PKT_EN
          USB_PKTEND_N <= 1'b0;
          pkt_cnt      <= '0;
`endif
          state <= S_WRITE;
        end
        default: begin
          state     <= S_IDLE;
          USB_FD_OE <= 1'b0;
        end
      endcase
    end
  end

  // Read-side controls are never used by this master; endpoint is fixed.
  always_ff @(posedge USB_IFCLK or posedge USB_RESET) begin
    if (USB_RESET) begin
      USB_SLRD_N  <= 1'b1;
      USB_SLOE_N  <= 1'b1;
      USB_FIFOADR <= EP_ADDR;
    end else begin
      USB_SLRD_N  <= 1'b1;
      USB_SLOE_N  <= 1'b1;
      USB_FIFOADR <= EP_ADDR;
    end
  end

  // Running count of words committed to the FX2.
  always_ff @(posedge USB_IFCLK or posedge USB_RESET) begin
    if (USB_RESET)        WORDS_SENT <= '0;
    else if (!USB_SLWR_N) WORDS_SENT <= WORDS_SENT + 32'd1;
  end

endmodule

// File: tb/tb_fx2_slave_fifo_writer.sv
// Testbench for fx2_slave_fifo_writer: hand-derived vector table, directed
// corner sequences and a randomized run checked by a queue-based model.
module tb_fx2_slave_fifo_writer;

  localparam int DEPTH_TB   = 16;
  localparam int TIMEOUT_TB = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        valid = 1'b0;
  logic        flagb_n = 1'b1;
  logic [15:0] din = '0;

  logic        IN_READY;
  logic [15:0] USB_FD;
  logic        USB_FD_OE, USB_SLWR_N, USB_SLRD_N, USB_SLOE_N, USB_PKTEND_N;
  logic [1:0]  USB_FIFOADR;
  logic [31:0] WORDS_SENT;

  fx2_slave_fifo_writer dut (
    .USB_IFCLK   (clk),
    .USB_RESET   (rst),
    .ENABLE      (en),
    .IN_DATA     (din),
    .IN_VALID    (valid),
    .IN_READY    (IN_READY),
    .USB_FLAGB_N (flagb_n),
    .USB_FD      (USB_FD),
    .USB_FD_OE   (USB_FD_OE),
    .USB_SLWR_N  (USB_SLWR_N),
    .USB_SLRD_N  (USB_SLRD_N),
    .USB_SLOE_N  (USB_SLOE_N),
    .USB_FIFOADR (USB_FIFOADR),
    .USB_PKTEND_N(USB_PKTEND_N),
    .WORDS_SENT  (WORDS_SENT)
  );

  initial forever #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: accepted words in order, strobes observed, occupancy.
  logic [15:0] exp_q[$];
  logic [15:0] hd;
  int  acc, strobes, cyc, last_strobe_cyc, cur_run, max_run, occ;
  bit  mon_on, pred_valid, pred_wr, en_prev, saw_full;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (mon_on) begin
      if (pred_valid) begin
`ifdef FX2_SHORT_PKT_EN
        if (!USB_SLWR_N) chk("slwr_allowed", 32'(pred_wr), 32'd1);
`else
        chk("slwr_timing", 32'(USB_SLWR_N), 32'(!pred_wr));
        chk("fd_oe_state", 32'(USB_FD_OE), 32'(en_prev));
`endif
      end
      chk("words_sent", WORDS_SENT, 32'(strobes));
      if (!USB_SLWR_N) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL extra_write: got SLWR with FD=0x%0h, expected no write (t=%0t)", USB_FD, $time);
        end else begin
          hd = exp_q.pop_front();
          chk("fd_data", 32'(USB_FD), 32'(hd));
        end
        chk("fd_oe_on_write", 32'(USB_FD_OE), 32'd1);
        strobes++;
        cur_run++;
        if (cur_run > max_run) max_run = cur_run;
        last_strobe_cyc = cyc;
      end else begin
        cur_run = 0;
      end
`ifdef FX2_SHORT_PKT_EN
      if (!USB_PKTEND_N) chk("pktend_no_overlap", 32'(USB_SLWR_N), 32'd1);
`else
      chk("pktend_idle", 32'(USB_PKTEND_N), 32'd1);
`endif
      chk("static_outs", {28'd0, USB_SLRD_N, USB_SLOE_N, USB_FIFOADR}, 32'hE);
      occ = acc - strobes;
      chk("in_ready", 32'(IN_READY), 32'(occ < DEPTH_TB));
      if (!IN_READY) saw_full = 1'b1;
      pred_wr    = en_prev && en && flagb_n && (occ > 0);
      pred_valid = 1'b1;
      en_prev    = en;
      if (valid && IN_READY) begin
        exp_q.push_back(din);
        acc++;
      end
    end
  end

  task automatic do_reset();
    mon_on = 1'b0;
    rst = 1'b1; en = 1'b0; valid = 1'b0; flagb_n = 1'b1; din = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    acc = 0; strobes = 0; cur_run = 0; max_run = 0;
    pred_valid = 1'b0; en_prev = 1'b0; saw_full = 1'b0;
    mon_on = 1'b1;
  endtask

  task automatic step(input bit e, input bit f, input bit v, input logic [15:0] d);
    @(posedge clk);
    #1;
    en = e; flagb_n = f; valid = v; din = d;
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_slwr_n"},   32'(USB_SLWR_N),   32'd1);
    chk({tag, "_pktend_n"}, 32'(USB_PKTEND_N), 32'd1);
    chk({tag, "_slrd_n"},   32'(USB_SLRD_N),   32'd1);
    chk({tag, "_sloe_n"},   32'(USB_SLOE_N),   32'd1);
    chk({tag, "_fd"},       32'(USB_FD),       32'd0);
    chk({tag, "_fd_oe"},    32'(USB_FD_OE),    32'd0);
    chk({tag, "_fifoadr"},  32'(USB_FIFOADR),  32'd2);
    chk({tag, "_in_ready"}, 32'(IN_READY),     32'd0);
    chk({tag, "_words"},    WORDS_SENT,        32'd0);
  endtask

  typedef struct packed {
    logic        e;
    logic        f;
    logic        v;
    logic [15:0] d;
    logic        slwr_n;
    logic        oe;
    logic        rdy;
    logic [15:0] fd;
    logic [31:0] ws;
  } vec_t;

  function automatic vec_t mk(input logic e, input logic f, input logic v, input logic [15:0] d,
                              input logic slwr_n, input logic oe, input logic rdy,
                              input logic [15:0] fd, input logic [31:0] ws);
    vec_t r;
    r.e = e; r.f = f; r.v = v; r.d = d;
    r.slwr_n = slwr_n; r.oe = oe; r.rdy = rdy; r.fd = fd; r.ws = ws;
    return r;
  endfunction

  vec_t tbl[13];
  int   fl_lo;
  int   s0;
  int   k;
  bit   got;

  initial begin
    // Expected outputs per cycle, derived by hand from the transfer rules.
    tbl[0]  = mk(1'b1, 1'b1, 1'b1, 16'hA1A1, 1'b1, 1'b0, 1'b1, 16'h0000, 32'd0);
    tbl[1]  = mk(1'b1, 1'b1, 1'b1, 16'hB2B2, 1'b1, 1'b1, 1'b1, 16'h0000, 32'd0);
    tbl[2]  = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'hA1A1, 32'd0);
    tbl[3]  = mk(1'b1, 1'b0, 1'b1, 16'hC3C3, 1'b0, 1'b1, 1'b1, 16'hB2B2, 32'd1);
    tbl[4]  = mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'hB2B2, 32'd2);
    tbl[5]  = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'hB2B2, 32'd2);
    tbl[6]  = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'hC3C3, 32'd2);
    tbl[7]  = mk(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'hC3C3, 32'd3);
    tbl[8]  = mk(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'hC3C3, 32'd3);
    tbl[9]  = mk(1'b1, 1'b1, 1'b1, 16'hD4D4, 1'b1, 1'b0, 1'b1, 16'hC3C3, 32'd3);
    tbl[10] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'hC3C3, 32'd3);
    tbl[11] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'hD4D4, 32'd3);
    tbl[12] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'hD4D4, 32'd4);

    mon_on = 1'b0;
    #1 rst = 1'b1;
    #1 check_reset_outputs("por");

    // Vector table
    do_reset();
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].e, tbl[i].f, tbl[i].v, tbl[i].d);
      chk($sformatf("tbl%0d_slwr_n", i), 32'(USB_SLWR_N), 32'(tbl[i].slwr_n));
      chk($sformatf("tbl%0d_fd_oe", i),  32'(USB_FD_OE),  32'(tbl[i].oe));
      chk($sformatf("tbl%0d_in_rdy", i), 32'(IN_READY),   32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_fd", i),     32'(USB_FD),     32'(tbl[i].fd));
      chk($sformatf("tbl%0d_words", i),  WORDS_SENT,      tbl[i].ws);
    end

    // Ten words back to back
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b1, 16'(i));
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 16'h0);
    chk("ten_words_sent", WORDS_SENT, 32'd10);
    chk("ten_words_run", 32'(max_run), 32'd10);

    // FLAGB# drop mid-burst, then a long drop that fills the buffer
    do_reset();
    k = 0;
    for (int i = 0; i < 12; i++) begin step(1'b1, 1'b1, 1'b1, 16'(k)); k++; end
    step(1'b1, 1'b0, 1'b1, 16'(k)); k++;
    chk("slwr_low_at_drop", 32'(USB_SLWR_N), 32'd0);
    step(1'b1, 1'b0, 1'b1, 16'(k)); k++;
    chk("slwr_high_after_drop", 32'(USB_SLWR_N), 32'd1);
    for (int i = 0; i < 3; i++) begin step(1'b1, 1'b0, 1'b1, 16'(k)); k++; end
    for (int i = 0; i < 8; i++) begin step(1'b1, 1'b1, 1'b1, 16'(k)); k++; end
    for (int i = 0; i < 20; i++) begin step(1'b1, 1'b0, 1'b1, 16'(k)); k++; end
    chk("in_ready_when_full", 32'(IN_READY), 32'd0);
    chk("full_seen", 32'(saw_full), 32'd1);
    for (int i = 0; i < 30; i++) step(1'b1, 1'b1, 1'b0, 16'h0);
    chk("flag_drained", 32'(exp_q.size()), 32'd0);
    chk("flag_words", WORDS_SENT, 32'(acc));

    // 300 words: packet counter wraps with no short-packet commit
    do_reset();
    for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 1'b1, 16'(i + 16'h1000));
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 16'h0);
    chk("w300_sent", WORDS_SENT, 32'd300);
    chk("w300_run", 32'(max_run), 32'd300);

    // ENABLE drop mid-burst, then resume
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 16'(16'h7000 + i));
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 16'h0);
    s0 = strobes;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 16'h0);
    chk("en_drop_extra_writes", 32'((strobes - s0) <= 1), 32'd1);
    chk("en_drop_fd_oe", 32'(USB_FD_OE), 32'd0);
    chk("en_drop_retained", 32'(exp_q.size()), 32'(8 - strobes));
    for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 1'b0, 16'h0);
    chk("en_resume_drained", 32'(exp_q.size()), 32'd0);
    chk("en_resume_words", WORDS_SENT, 32'd8);

    // Asynchronous reset during a burst
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b1, 16'(16'h5000 + i));
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 16'(16'h5100 + i));
    @(negedge clk);
    #2;
    mon_on = 1'b0;
    rst = 1'b1;
    #1 check_reset_outputs("async");
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 16'h0);
    chk("post_reset_strobes", 32'(strobes), 32'd0);
    chk("post_reset_words", WORDS_SENT, 32'd0);
    chk("post_reset_ready", 32'(IN_READY), 32'd1);

`ifdef FX2_SHORT_PKT_EN
    // Short packet committed after the idle timeout
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 16'(16'h3000 + i));
    got = 1'b0;
    for (int i = 0; i < TIMEOUT_TB + 50 && !got; i++) begin
      step(1'b1, 1'b1, 1'b0, 16'h0);
      if (!USB_PKTEND_N) begin
        got = 1'b1;
        chk("pktend_delay", 32'(cyc - last_strobe_cyc), 32'(TIMEOUT_TB + 1));
      end
    end
    chk("pktend_seen", 32'(got), 32'd1);
    step(1'b1, 1'b1, 1'b0, 16'h0);
    chk("pktend_one_cycle", 32'(USB_PKTEND_N), 32'd1);
    chk("short_pkt_words", WORDS_SENT, 32'd3);
`endif

    // Randomized traffic against the queue model
    do_reset();
    fl_lo = 0;
    for (int i = 0; i < 2500; i++) begin
      if (fl_lo > 0) fl_lo--;
      else if ($urandom_range(0, 15) == 0) fl_lo = int'($urandom_range(1, 8));
      step($urandom_range(0, 19) != 0, fl_lo == 0, $urandom_range(0, 3) != 0, 16'($urandom));
    end
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0, 16'h0);
    chk("rand_drained", 32'(exp_q.size()), 32'd0);
    chk("rand_words", WORDS_SENT, 32'(acc));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
